// File: rtl/conv1_pkg.sv
// conv1_pkg: shared constants and types for the conv1 window generator.
//   IMG_W / IMG_H      default image geometry (28x28 MNIST)
//   KERNEL_SIZE        convolution kernel edge (3)
//   WINDOW_SIZE        pixels per window (9)
//   OUT_W / OUT_H      output feature-map geometry
//   COL_W / ROW_W      counter widths for the default geometry
//   POS_W              width of the output-map coordinates
//   conv1_state_t      window generator FSM states
package conv1_pkg;

  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int KERNEL_SIZE = 3;
  localparam int WINDOW_SIZE = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OUT_W       = IMG_W - 2;
  localparam int OUT_H       = IMG_H - 2;
  localparam int COL_W       = $clog2(IMG_W);
  localparam int ROW_W       = $clog2(IMG_H);
  localparam int POS_W       = $clog2(OUT_W);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } conv1_state_t;

endpackage

// File: rtl/conv1_line_buf.sv
// conv1_line_buf: LEN-bit enable-gated shift register holding the last LEN
// accepted pixels (two image rows plus three pixels in the window generator).
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high clear
//   en   in   shift enable; state holds while low
//   din  in   bit shifted into q[0]
//   q    out  full register contents, q[0] newest, q[LEN-1] oldest
module conv1_line_buf #(
  parameter int LEN = 59
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           din,
  output logic [LEN-1:0] q
);

  // Shift register: newest bit enters at the bottom on every enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[LEN-2:0], din};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/conv1_window_buf.sv
// conv1_window_buf: streaming 3x3 window generator for the first binary
// convolution layer. Consumes a raster-order 1-bit pixel stream and presents
// every complete 3x3 window with a one-cycle valid strobe.
// Ports:
//   clk               in   rising-edge clock
//   rst               in   asynchronous active-high reset
//   pixel_in          in   binary pixel, raster order
//   valid_in          in   pixel_in accepted on any edge where high
//   pixel_0..pixel_8  out  window bits, pixel_0 top-left (oldest),
//                          pixel_8 bottom-right (newest)
//   valid_in_buf      out  one-cycle window strobe
//   frame_done        out  one-cycle pulse after the last pixel of a frame
//   win_row, win_col  out  output-map coordinate of the emitted window
//                          (only when CONV1_WIN_POS_EN is defined)
// Optional feature macro: CONV1_WIN_POS_EN
module conv1_window_buf #(
  parameter int IMG_W = conv1_pkg::IMG_W,
  parameter int IMG_H = conv1_pkg::IMG_H
) (
  input  logic clk,
  input  logic rst,
  input  logic pixel_in,
  input  logic valid_in,
  output logic pixel_0,
  output logic pixel_1,
  output logic pixel_2,
  output logic pixel_3,
  output logic pixel_4,
  output logic pixel_5,
  output logic pixel_6,
  output logic pixel_7,
  output logic pixel_8,
  output logic valid_in_buf,
  output logic frame_done
`ifdef CONV1_WIN_POS_EN
  ,
  output logic [$clog2(IMG_W-2)-1:0] win_row,
  output logic [$clog2(IMG_W-2)-1:0] win_col
`endif
);

  import conv1_pkg::*;

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int SR_LEN = 2 * IMG_W + KERNEL_SIZE;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);

`ifdef CONV1_WIN_POS_EN
  localparam int PW = $clog2(IMG_W - 2);
`endif

  conv1_state_t      state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [SR_LEN-1:0] sr;
  logic              col_last;
  logic              row_last;
  logic              emit;
  logic              last_pixel;
  logic              unused_sr_bits;

  conv1_line_buf #(
    .LEN (SR_LEN)
  ) u_line_buf (
    .clk (clk),
    .rst (rst),
    .en  (valid_in),
    .din (pixel_in),
    .q   (sr)
  );

  // Window taps: three rows of the image, each IMG_W apart in the delay line.
  assign pixel_8 = sr[0];
  assign pixel_7 = sr[1];
  assign pixel_6 = sr[2];
  assign pixel_5 = sr[IMG_W];
  assign pixel_4 = sr[IMG_W+1];
  assign pixel_3 = sr[IMG_W+2];
  assign pixel_2 = sr[2*IMG_W];
  assign pixel_1 = sr[2*IMG_W+1];
  assign pixel_0 = sr[2*IMG_W+2];

  // The bits between taps are pure delay; folding them here marks them as
  // intentionally not observed.
  assign unused_sr_bits = ^sr;

  // Accept-side decode for the pixel on the bus this cycle. STREAM is
  // exactly row >= 2, so emission only needs the column test on top of it;
  // columns 0 and 1 would produce windows straddling two image rows.
  always_comb begin
    col_last   = (col == COL_LAST);
    row_last   = (row == ROW_LAST);
    emit       = valid_in && (state == STREAM) && (col >= COL_FIRST);
    last_pixel = valid_in && (state == STREAM) && row_last && col_last;
  end

  // FSM, raster counters and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL;
      row          <= '0;
      col          <= '0;
      valid_in_buf <= 1'b0;
      frame_done   <= 1'b0;
`ifdef CONV1_WIN_POS_EN
      win_row      <= '0;
      win_col      <= '0;
`endif
    end else begin
      valid_in_buf <= emit;
      frame_done   <= last_pixel;

      if (valid_in) begin
        case (state)
          FILL: begin
            if ((row == ROW_ONE) && col_last) begin
              state <= STREAM;
            end else begin
              state <= FILL;
            end
          end
          STREAM: begin
            if (row_last && col_last) begin
              state <= FILL;
            end else begin
              state <= STREAM;
            end
          end
          default: state <= FILL;
        endcase

        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row <= '0;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end

`ifdef CONV1_WIN_POS_EN
      // Coordinates track the strobe and hold between windows.
      if (emit) begin
        win_row <= PW'(row - RW'(2));
        win_col <= PW'(col - CW'(2));
      end
`endif
    end
  end

endmodule
